// File: rtl/oled_pkg.sv
// Shared definitions for the OLED panel SPI transmitter: FSM encoding and divider default.
package oled_pkg;

    localparam int OLED_CLK_DIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } oled_state_e;

endpackage

// File: rtl/oled_spi_div.sv
// SCLK half-period tick generator: counts 0..CLK_DIV-1 while enabled, held at zero otherwise.
module oled_spi_div
    import oled_pkg::*;
#(
    parameter int CLK_DIV = OLED_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [7:0] TC = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || (cnt_q == TC)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = enable && (cnt_q == TC);

endmodule

// File: rtl/oled_spi_tx.sv
// Byte-wide SPI mode-0 transmitter for an OLED panel with registered D/C and chip select.
// state | meaning
// IDLE  | cs_n high, waiting for spi_send; dc holds last latched value
// SHIFT | cs_n low, sclk toggling on divider ticks, 8 bits MSB first
// DONE  | one-cycle send_done pulse, cs_n high, back to IDLE
module oled_spi_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV = OLED_CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_send,
    input  logic [7:0] spi_data,
    input  logic       dc_in,
    output logic       send_done,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       dc
);

    oled_state_e state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        sclk_q, sclk_d;
    logic        cs_n_q, cs_n_d;
    logic        dc_q, dc_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        tick;

    oled_spi_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == ST_SHIFT),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        dc_d     = dc_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (spi_send) begin
                    state_d  = ST_SHIFT;
                    shreg_d  = spi_data;
                    dc_d     = dc_in;
                    cs_n_d   = 1'b0;
                    sclk_d   = 1'b0;
                    bitcnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    // Data only moves on the falling edge; the panel samples on the rising one.
                    if (sclk_q) begin
                        if (bitcnt_q == 3'd7) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            cs_n_d  = 1'b1;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            sclk_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            dc_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            dc_q     <= dc_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign send_done = done_q;
    assign busy      = busy_q;
    assign sclk      = sclk_q;
    assign mosi      = shreg_q[7];
    assign cs_n      = cs_n_q;
    assign dc        = dc_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Scoreboard bench for oled_spi_tx: lane 0 runs CLK_DIV=4, lane 1 runs CLK_DIV=1.
module tb_oled_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, send0, dcin0, done0, busy0, sclk0, mosi0, csn0, dc0;
    logic [7:0] data0;
    logic       rst1, send1, dcin1, done1, busy1, sclk1, mosi1, csn1, dc1;
    logic [7:0] data1;

    oled_spi_tx #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .reset(rst0), .spi_send(send0), .spi_data(data0), .dc_in(dcin0),
        .send_done(done0), .busy(busy0), .sclk(sclk0), .mosi(mosi0), .cs_n(csn0), .dc(dc0)
    );

    oled_spi_tx #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .reset(rst1), .spi_send(send1), .spi_data(data1), .dc_in(dcin1),
        .send_done(done1), .busy(busy1), .sclk(sclk1), .mosi(mosi1), .cs_n(csn1), .dc(dc1)
    );

    // gap = required cs_n-high cycles before this byte (0 = unchecked); done_edge counts from acceptance
    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         gap;
        int         done_edge;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail(input string nm);
        n_total++;
        $display("FAIL %s: got event expected none (cycle %0d)", nm, cyc);
    endtask

    bit         in_b[2]      = '{0, 0};
    int         nb[2]        = '{0, 0};
    logic [7:0] cap[2]       = '{8'h00, 8'h00};
    int         acc[2]       = '{0, 0};
    int         last_rise[2] = '{0, 0};
    int         hi_run[2]    = '{0, 0};
    bit         p_sclk[2]    = '{0, 0};
    bit         p_cs[2]      = '{1, 1};
    bit         p_done[2]    = '{0, 0};

    task automatic qpop(input int ln);
        if (ln == 0) q0.delete(0);
        else q1.delete(0);
    endtask

    task automatic mon(input int ln, input int dv, input logic r, input logic sd,
                       input logic bz, input logic sc, input logic mo, input logic cs,
                       input logic d);
        exp_t e;
        int   qs;
        qs = (ln == 0) ? q0.size() : q1.size();
        e  = '{8'h00, 1'b0, 0, 0};
        if (qs > 0) e = (ln == 0) ? q0[0] : q1[0];
        if (r) begin
            if (in_b[ln] && qs > 0) qpop(ln);
            in_b[ln] = 0; p_sclk[ln] = 0; p_cs[ln] = 1; p_done[ln] = 0; hi_run[ln] = 0;
            return;
        end
        if (p_done[ln]) chk("done_single_pulse", int'(sd), 0);
        if (p_cs[ln] && !cs) begin
            if (qs == 0) fail("unexpected_accept");
            else begin
                if (e.gap != 0) chk("cs_n_gap", hi_run[ln], e.gap);
                in_b[ln] = 1; nb[ln] = 0; cap[ln] = 8'h00;
                acc[ln] = cyc; last_rise[ln] = cyc;
            end
        end
        if (cs) hi_run[ln]++;
        else hi_run[ln] = 0;
        if (sc && !p_sclk[ln]) begin
            if (!in_b[ln]) fail("stray_sclk_rise");
            else begin
                nb[ln]++;
                cap[ln] = {cap[ln][6:0], mo};
                chk("sclk_rise_spacing", cyc - last_rise[ln], (nb[ln] == 1) ? dv : 2 * dv);
                last_rise[ln] = cyc;
                chk("dc_stable", int'(d), int'(e.dc));
            end
        end
        if (sd) begin
            if (!in_b[ln] || qs == 0) fail("unexpected_done");
            else begin
                qpop(ln);
                chk("byte_bits", int'(cap[ln]), int'(e.data));
                chk("sclk_rises", nb[ln], 8);
                chk("done_edge", cyc - acc[ln] + 1, e.done_edge);
                chk("done_cs_n", int'(cs), 1);
                chk("done_sclk", int'(sc), 0);
                chk("done_busy", int'(bz), 1);
                in_b[ln] = 0;
            end
        end
        p_sclk[ln] = sc; p_cs[ln] = cs; p_done[ln] = sd;
    endtask

    always @(negedge clk) begin
        mon(0, 4, rst0, done0, busy0, sclk0, mosi0, csn0, dc0);
        mon(1, 1, rst1, done1, busy1, sclk1, mosi1, csn1, dc1);
    end

    task automatic wait_done(input int ln, input int maxc);
        bit seen;
        seen = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if ((ln == 0) ? done0 : done1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail("timeout_send_done");
    endtask

    task automatic send_byte0(input logic [7:0] b, input logic d);
        @(posedge clk); #1;
        send0 = 1'b1; data0 = b; dcin0 = d;
        @(posedge clk); #1;
        send0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst0 = 1'b1; send0 = 1'b0; data0 = 8'h00; dcin0 = 1'b0;
        rst1 = 1'b1; send1 = 1'b0; data1 = 8'h00; dcin1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", int'(csn0), 1);
        chk("rst_sclk", int'(sclk0), 0);
        chk("rst_mosi", int'(mosi0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_dc", int'(dc0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_cs_n_div1", int'(csn1), 1);

        // single byte A5 with data flag
        q0.push_back('{8'hA5, 1'b1, 0, 65});
        send_byte0(8'hA5, 1'b1);
        data0 = 8'h00; dcin0 = 1'b0;
        wait_done(0, 120);
        @(negedge clk);
        chk("after_done_busy", int'(busy0), 0);
        chk("after_done_cs_n", int'(csn0), 1);
        repeat (5) @(negedge clk);
        chk("idle_dc_hold", int'(dc0), 1);
        chk("idle_cs_n", int'(csn0), 1);

        // request held high, upstream advances data on each send_done edge
        q0.push_back('{8'hB0, 1'b0, 0, 65});
        q0.push_back('{8'h10, 1'b0, 2, 65});
        q0.push_back('{8'h00, 1'b0, 2, 65});
        @(posedge clk); #1;
        send0 = 1'b1; data0 = 8'hB0; dcin0 = 1'b0;
        wait_done(0, 120);
        @(posedge clk); #1;
        data0 = 8'h10;
        wait_done(0, 120);
        @(posedge clk); #1;
        data0 = 8'h00;
        wait_done(0, 120);
        @(posedge clk); #1;
        send0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("stream_end_busy", int'(busy0), 0);

        // reset on the 4th sclk rising edge of FF aborts the byte
        q0.push_back('{8'hFF, 1'b1, 0, 65});
        send_byte0(8'hFF, 1'b1);
        repeat (27) @(posedge clk);
        #1 rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", int'(csn0), 1);
        chk("abort_sclk", int'(sclk0), 0);
        chk("abort_mosi", int'(mosi0), 0);
        chk("abort_busy", int'(busy0), 0);
        chk("abort_dc", int'(dc0), 0);
        repeat (80) @(negedge clk);
        q0.push_back('{8'h96, 1'b0, 0, 65});
        send_byte0(8'h96, 1'b0);
        wait_done(0, 120);
        repeat (3) @(negedge clk);

        // reset wins over a simultaneous request
        @(posedge clk); #1;
        rst0 = 1'b1; send0 = 1'b1; data0 = 8'h55;
        @(posedge clk); #1;
        rst0 = 1'b0; send0 = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", int'(busy0), 0);
        chk("rst_prio_cs_n", int'(csn0), 1);
        repeat (5) @(negedge clk);

        // inputs wiggled mid-byte are ignored
        q0.push_back('{8'h3C, 1'b0, 0, 65});
        send_byte0(8'h3C, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        data0 = 8'hC3; dcin0 = 1'b1; send0 = 1'b1;
        repeat (20) @(posedge clk);
        #1 send0 = 1'b0;
        wait_done(0, 120);
        repeat (6) @(negedge clk);
        chk("dc_hold_vs_dc_in", int'(dc0), 0);
        chk("no_resend_busy", int'(busy0), 0);
        dcin0 = 1'b0;

        // fastest divider
        q1.push_back('{8'h81, 1'b1, 0, 17});
        @(posedge clk); #1;
        send1 = 1'b1; data1 = 8'h81; dcin1 = 1'b1;
        @(posedge clk); #1;
        send1 = 1'b0; data1 = 8'h00; dcin1 = 1'b0;
        wait_done(1, 60);
        repeat (4) @(negedge clk);
        chk("div1_dc_hold", int'(dc1), 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
